morra_match_driver: RTL and testbench
=====================================

Name: morra_match_driver

Overview:
Host-side driver for the MorraCinese game FSMD. Accepts one match configuration and a stream of move pairs over valid/ready handshakes. Issues the START cycle, feeds one move pair per clock into P1/P2, watches the FSMD's ROUND/GAME outputs, and tallies round results. Reports a one-cycle match result record when GAME resolves, or raises a timeout error.

Parameters:
MAX_CYCLES, 64, PLAY cycles allowed before the match is aborted with timeout.
CNT_W, 5, width of all round/win counters; the counters saturate at all-ones.

Ports:
clk  in  1  clock; everything is on the rising edge
rst  in  1  reset
cfg_valid  in  1  match request
cfg_ready  out  1  high only in IDLE
cfg_extra  in  4  value driven as {P1,P2} during the START cycle (extra-round setting)
mv_valid  in  1  move pair available
mv_ready  out  1  move pair consumed this cycle
mv_p1  in  2  player 1 move (01 rock, 10 paper, 11 scissors, 00 invalid)
mv_p2  in  2  player 2 move
P1  out  2  to FSMD
P2  out  2  to FSMD
START  out  1  to FSMD
ROUND  in  2  from FSMD: 00 none/invalid, 01 P1, 10 P2, 11 draw
GAME  in  2  from FSMD: 00 running, 01 P1, 10 P2, 11 draw
res_valid  out  1  one-cycle result pulse
res_winner  out  2  final GAME code
res_rounds  out  CNT_W  count of cycles with ROUND != 00
res_p1_wins  out  CNT_W  count of ROUND = 01
res_p2_wins  out  CNT_W  count of ROUND = 10
res_draws  out  CNT_W  count of ROUND = 11
res_timeout  out  1  valid with res_valid; when set, res_winner = 00
busy  out  1  state != IDLE
starve  out  1  sticky per match: a PLAY cycle occurred with mv_valid = 0

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state IDLE. P1, P2, START, res_*, starve and all counters are 0. cfg_ready = 1 after reset.
- Reset mid-match aborts to IDLE. No result is produced. The FSMD recovers on the next START.
- FSMD timing contract: the FSMD registers P1/P2/START on an edge. The ROUND/GAME outputs for that sample are valid throughout the following cycle.
- IDLE:
  - Drive P1 = P2 = 00 and START = 0.
  - When cfg_valid and cfg_ready: clear counters and starve, then go to START.
- START (exactly 1 cycle):
  - Drive START = 1, P1 = cfg_extra[3:2], P2 = cfg_extra[1:0], latched at the handshake.
  - Next state is PLAY.
- PLAY, each cycle:
  - Tally: if ROUND != 00, increment res_rounds and the matching win or draw counter.
  - If GAME != 00 (combinational check):
    - mv_ready = 0; drive 00/00.
    - Latch res_winner = GAME, res_timeout = 0.
    - Go to DONE.
  - Else, if the cycle counter equals MAX_CYCLES-1:
    - mv_ready = 0; drive 00/00.
    - Set res_timeout = 1, res_winner = 00.
    - Go to DONE.
  - Else, if mv_valid: mv_ready = 1 and drive P1 = mv_p1, P2 = mv_p2 this cycle (combinational pass-through).
  - Else: drive 00/00, which the FSMD treats as an invalid round, and set starve.
  - START is 0 throughout PLAY.
  - The first PLAY cycle sees ROUND/GAME for the START sample, expected 00/00. Any stale GAME from the previous match is never sampled in PLAY.
- Simultaneous GAME != 00 and timeout: GAME wins, so res_timeout = 0.
- DONE (1 cycle):
  - res_valid = 1 with all res_* fields stable.
  - The res_* fields hold their values until the next match START.
  - Drive 00/00, START = 0. Next state is IDLE.
- Tallying stops once GAME != 00 has been seen; that final cycle's ROUND is counted.
- Move latency: a move accepted in cycle t is sampled by the FSMD at the end of t. Its ROUND is counted in cycle t+1.

Decomposition:
- morra_pkg holds:
  - move codes: MV_NONE, MV_ROCK, MV_PAPER, MV_SCISSORS;
  - result codes: RES_NONE, RES_P1, RES_P2, RES_DRAW (shared by ROUND and GAME);
  - the state enum: ST_IDLE, ST_START, ST_PLAY, ST_DONE.
- One sub-module, morra_tally: the four saturating counters, plus clear and enable inputs, driven by ROUND.

Test Plan:
- P1 sweep: cfg_extra = 0000; moves (01,11) ×4. Scripted responder returns ROUND = 01 in cycles 2–5 after START, and GAME = 01 with the 4th.
  -> res_valid once; winner = 01, rounds = 4, p1_wins = 4, p2/draws = 0.
  -> START high for exactly 1 cycle with P1 = P2 = 00.
- Config pass-through: cfg_extra = 1011 -> in the START cycle, P1 = 10, P2 = 11, START = 1.
- Starvation: mv_valid drops for 2 PLAY cycles.
  -> P1 = P2 = 00 in those cycles, starve = 1, mv_ready = 0 there.
  -> Match still completes with winner = 10 on the responder's GAME = 10.
- End-of-game gating: mv_valid held high, responder GAME = 11 in cycle k.
  -> mv_ready = 0 in cycle k, so the pending move is retained and not consumed.
  -> res_winner = 11, res_draws equals the scripted count.
- Timeout: MAX_CYCLES = 8, responder GAME stays 00.
  -> After 8 PLAY cycles, res_valid with res_timeout = 1 and winner = 00; back in IDLE with cfg_ready = 1.
- Reset mid-PLAY: assert rst for 1 cycle.
  -> Next cycle state IDLE; all outputs 0; no res_valid.
  -> A following match behaves identically to the first scenario.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings for the MorraCinese match driver: move codes,
// ROUND/GAME result codes and the driver state machine.
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/morra_tally.sv
// Saturating round/win/draw counters fed by the FSMD ROUND output.
module morra_tally
    import morra_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       round,
    output logic [CNT_W-1:0] rounds,
    output logic [CNT_W-1:0] p1_wins,
    output logic [CNT_W-1:0] p2_wins,
    output logic [CNT_W-1:0] draws
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rounds  <= '0;
            p1_wins <= '0;
            p2_wins <= '0;
            draws   <= '0;
        end else if (en && round != RES_NONE) begin
            rounds <= sat_inc(rounds);
            case (round)
                RES_P1:  p1_wins <= sat_inc(p1_wins);
                RES_P2:  p2_wins <= sat_inc(p2_wins);
                default: draws   <= sat_inc(draws);
            endcase
        end
    end

endmodule

// File: rtl/morra_match_driver.sv
// Host-side driver for the MorraCinese FSMD: issues START, streams move
// pairs, tallies ROUND results and reports one result record per match.
module morra_match_driver
    import morra_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 64,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_extra,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [1:0]       mv_p1,
    input  logic [1:0]       mv_p2,
    output logic [1:0]       P1,
    output logic [1:0]       P2,
    output logic             START,
    input  logic [1:0]       ROUND,
    input  logic [1:0]       GAME,
    output logic             res_valid,
    output logic [1:0]       res_winner,
    output logic [CNT_W-1:0] res_rounds,
    output logic [CNT_W-1:0] res_p1_wins,
    output logic [CNT_W-1:0] res_p2_wins,
    output logic [CNT_W-1:0] res_draws,
    output logic             res_timeout,
    output logic             busy,
    output logic             starve
);

    localparam int unsigned CYC_W = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       extra_q;
    logic [CYC_W-1:0] cyc_q;
    logic             hs;
    logic             fin_game;
    logic             fin_to;
    logic             starve_set;
    logic             tally_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            extra_q     <= '0;
            cyc_q       <= '0;
            res_winner  <= '0;
            res_timeout <= 1'b0;
            starve      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                extra_q     <= cfg_extra;
                cyc_q       <= '0;
                res_winner  <= '0;
                res_timeout <= 1'b0;
                starve      <= 1'b0;
            end
            if (state_q == ST_PLAY)
                cyc_q <= cyc_q + CYC_W'(1);
            if (fin_game) begin
                res_winner  <= GAME;
                res_timeout <= 1'b0;
            end else if (fin_to) begin
                res_winner  <= RES_NONE;
                res_timeout <= 1'b1;
            end
            if (starve_set)
                starve <= 1'b1;
        end
    end

    // GAME is checked before the timeout so a resolving game on the last
    // allowed cycle still reports a winner.
    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b0;
        mv_ready   = 1'b0;
        P1         = MV_NONE;
        P2         = MV_NONE;
        START      = 1'b0;
        hs         = 1'b0;
        fin_game   = 1'b0;
        fin_to     = 1'b0;
        starve_set = 1'b0;
        tally_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    hs      = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                START   = 1'b1;
                P1      = extra_q[3:2];
                P2      = extra_q[1:0];
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                tally_en = 1'b1;
                if (GAME != RES_NONE) begin
                    fin_game = 1'b1;
                    state_d  = ST_DONE;
                end else if (cyc_q == CYC_LAST) begin
                    fin_to  = 1'b1;
                    state_d = ST_DONE;
                end else if (mv_valid) begin
                    mv_ready = 1'b1;
                    P1       = mv_p1;
                    P2       = mv_p2;
                end else begin
                    starve_set = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);

    morra_tally #(
        .CNT_W(CNT_W)
    ) u_tally (
        .clk     (clk),
        .rst     (rst),
        .clr     (hs),
        .en      (tally_en),
        .round   (ROUND),
        .rounds  (res_rounds),
        .p1_wins (res_p1_wins),
        .p2_wins (res_p2_wins),
        .draws   (res_draws)
    );

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver; the bench plays the FSMD by
// scripting ROUND/GAME per cycle.
module tb_morra_match_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_extra;
    logic       mv_valid;
    logic       mv_ready;
    logic [1:0] mv_p1, mv_p2;
    logic [1:0] P1, P2;
    logic       START;
    logic [1:0] ROUND, GAME;
    logic       res_valid;
    logic [1:0] res_winner;
    logic [4:0] res_rounds, res_p1_wins, res_p2_wins, res_draws;
    logic       res_timeout;
    logic       busy;
    logic       starve;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    morra_match_driver #(
        .MAX_CYCLES(8),
        .CNT_W     (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_extra   (cfg_extra),
        .mv_valid    (mv_valid),
        .mv_ready    (mv_ready),
        .mv_p1       (mv_p1),
        .mv_p2       (mv_p2),
        .P1          (P1),
        .P2          (P2),
        .START       (START),
        .ROUND       (ROUND),
        .GAME        (GAME),
        .res_valid   (res_valid),
        .res_winner  (res_winner),
        .res_rounds  (res_rounds),
        .res_p1_wins (res_p1_wins),
        .res_p2_wins (res_p2_wins),
        .res_draws   (res_draws),
        .res_timeout (res_timeout),
        .busy        (busy),
        .starve      (starve)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (res_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] r, input logic [1:0] g);
        mv_valid = v;
        mv_p1    = a;
        mv_p2    = b;
        ROUND    = r;
        GAME     = g;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IDLE handshake cycle followed by the START cycle.
    task automatic start_match(input logic [3:0] extra);
        cfg_valid = 1'b1;
        cfg_extra = extra;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("idle_cfg_ready", cfg_ready, 1);
        chk("idle_start", START, 0);
        tick();
        cfg_valid = 1'b0;
        cfg_extra = 4'b0000;
        drive(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        chk("st_start", START, 1);
        chk("st_p1", P1, extra[3:2]);
        chk("st_p2", P2, extra[1:0]);
        chk("st_mv_ready", mv_ready, 0);
        chk("st_cfg_ready", cfg_ready, 0);
        tick();
    endtask

    task automatic run_sweep(input int exp_pulses);
        start_match(4'b0000);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b01, 2'b11, (i == 1) ? 2'b00 : 2'b01, 2'b00);
            chk("sw_mv_ready", mv_ready, 1);
            chk("sw_p1", P1, 2'b01);
            chk("sw_p2", P2, 2'b11);
            chk("sw_start", START, 0);
            chk("sw_res_valid", res_valid, 0);
            tick();
        end
        drive(1'b0, 2'b00, 2'b00, 2'b01, 2'b01);
        chk("sw_end_mv_ready", mv_ready, 0);
        chk("sw_end_p1", P1, 0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("sw_res_valid", res_valid, 1);
        chk("sw_winner", res_winner, 2'b01);
        chk("sw_rounds", res_rounds, 4);
        chk("sw_p1_wins", res_p1_wins, 4);
        chk("sw_p2_wins", res_p2_wins, 0);
        chk("sw_draws", res_draws, 0);
        chk("sw_timeout", res_timeout, 0);
        tick();
        chk("sw_idle_valid", res_valid, 0);
        chk("sw_idle_ready", cfg_ready, 1);
        chk("sw_hold_rounds", res_rounds, 4);
        chk("sw_pulses", pulses, exp_pulses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_extra = 4'b0000;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", START, 0);
        chk("rst_p1p2", {P1, P2}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_counters", {res_rounds, res_p1_wins, res_p2_wins, res_draws}, 0);
        chk("rst_starve", starve, 0);
        tick();

        // P1 sweep
        run_sweep(1);

        // config pass-through plus starvation
        start_match(4'b1011);
        drive(1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
        chk("sv_starve0", starve, 0);
        tick();
        drive(1'b1, 2'b10, 2'b01, 2'b10, 2'b00);
        tick();
        drive(1'b0, 2'b10, 2'b01, 2'b10, 2'b00);
        chk("sv_mv_ready_a", mv_ready, 0);
        chk("sv_p1p2_a", {P1, P2}, 0);
        tick();
        drive(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
        chk("sv_starve1", starve, 1);
        chk("sv_mv_ready_b", mv_ready, 0);
        chk("sv_p1p2_b", {P1, P2}, 0);
        tick();
        drive(1'b1, 2'b10, 2'b01, 2'b00, 2'b00);
        chk("sv_mv_ready_c", mv_ready, 1);
        chk("sv_p1p2_c", {P1, P2}, 4'b1001);
        tick();
        drive(1'b1, 2'b10, 2'b01, 2'b10, 2'b10);
        chk("sv_end_mv_ready", mv_ready, 0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("sv_res_valid", res_valid, 1);
        chk("sv_winner", res_winner, 2'b10);
        chk("sv_rounds", res_rounds, 3);
        chk("sv_p2_wins", res_p2_wins, 3);
        chk("sv_p1_wins", res_p1_wins, 0);
        chk("sv_starve_done", starve, 1);
        chk("sv_timeout", res_timeout, 0);
        tick();

        // end-of-game gating with mv_valid held high
        start_match(4'b0000);
        drive(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        chk("eg_starve_cleared", starve, 0);
        tick();
        drive(1'b1, 2'b01, 2'b01, 2'b11, 2'b00);
        chk("eg_mv_ready", mv_ready, 1);
        tick();
        drive(1'b1, 2'b01, 2'b01, 2'b11, 2'b11);
        chk("eg_gate_mv_ready", mv_ready, 0);
        chk("eg_gate_p1p2", {P1, P2}, 0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("eg_res_valid", res_valid, 1);
        chk("eg_winner", res_winner, 2'b11);
        chk("eg_draws", res_draws, 2);
        chk("eg_rounds", res_rounds, 2);
        tick();

        // timeout after 8 PLAY cycles
        start_match(4'b0000);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'b01, 2'b11, (i == 1) ? 2'b00 : 2'b01, 2'b00);
            chk("to_mv_ready", mv_ready, (i != 8) ? 1 : 0);
            tick();
        end
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("to_res_valid", res_valid, 1);
        chk("to_timeout", res_timeout, 1);
        chk("to_winner", res_winner, 0);
        chk("to_rounds", res_rounds, 7);
        chk("to_p1_wins", res_p1_wins, 7);
        tick();
        chk("to_idle_ready", cfg_ready, 1);
        chk("to_idle_busy", busy, 0);
        chk("to_hold_timeout", res_timeout, 1);

        // GAME resolves on the last allowed cycle
        start_match(4'b0000);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'b10, 2'b01, (i == 1) ? 2'b00 : 2'b10, (i == 8) ? 2'b10 : 2'b00);
            if (i == 1) chk("sim_timeout_cleared", res_timeout, 0);
            tick();
        end
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("sim_res_valid", res_valid, 1);
        chk("sim_timeout", res_timeout, 0);
        chk("sim_winner", res_winner, 2'b10);
        chk("sim_p2_wins", res_p2_wins, 7);
        tick();

        // reset mid-PLAY
        start_match(4'b0000);
        drive(1'b1, 2'b01, 2'b11, 2'b00, 2'b00);
        tick();
        drive(1'b1, 2'b01, 2'b11, 2'b01, 2'b00);
        tick();
        drive(1'b1, 2'b01, 2'b11, 2'b01, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("mr_busy", busy, 0);
        chk("mr_cfg_ready", cfg_ready, 1);
        chk("mr_res_valid", res_valid, 0);
        chk("mr_counters", {res_rounds, res_p1_wins, res_p2_wins, res_draws}, 0);
        chk("mr_outs", {START, P1, P2, mv_ready, starve}, 0);
        tick();
        chk("mr_no_pulse", pulses, 5);

        run_sweep(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
